// File: rtl/dsp_mac_frame.sv
// Signed multiply-accumulate slice with an optional D+/-B pre-adder. It sums one frame of
// products over a runtime length and has valid/ready flow control on the input and output sides.
module dsp_mac_frame #(
    parameter int A_WIDTH   = 18,
    parameter int B_WIDTH   = 18,
    parameter int ACC_WIDTH = 48,
    parameter int LEN_WIDTH = 8,
    parameter int PRE_ADD   = 1,
    parameter int SATURATE  = 1
) (
    input  logic                        CLK,
    input  logic                        RSTN,
    input  logic                        CLEAR,
    input  logic                        IN_VALID,
    output logic                        IN_READY,
    input  logic signed [A_WIDTH-1:0]   A,
    input  logic signed [B_WIDTH-1:0]   B,
    input  logic signed [B_WIDTH-1:0]   D,
    input  logic                        PRE_SUB,
    input  logic [LEN_WIDTH-1:0]        FRAME_LEN,
    output logic                        OUT_VALID,
    input  logic                        OUT_READY,
    output logic signed [ACC_WIDTH-1:0] P,
    output logic                        OVF
);
    localparam int PROD_W = A_WIDTH + B_WIDTH + 1;

    logic adv;
    logic accept;

    logic signed [B_WIDTH:0] d_ext;
    logic signed [B_WIDTH:0] b_ext;
    logic signed [B_WIDTH:0] pre_sum;

    logic [LEN_WIDTH-1:0] cnt;
    logic [LEN_WIDTH-1:0] len_q;
    logic [LEN_WIDTH-1:0] len_eff;
    logic                 first_in;
    logic                 last_in;

    logic                      s1_valid;
    logic                      s1_first;
    logic                      s1_last;
    logic signed [A_WIDTH-1:0] s1_a;
    logic signed [B_WIDTH:0]   s1_b;

    logic                     s2_valid;
    logic                     s2_first;
    logic                     s2_last;
    logic signed [PROD_W-1:0] s2_prod;
    logic signed [PROD_W-1:0] mul_a;
    logic signed [PROD_W-1:0] mul_b;

    logic signed [ACC_WIDTH-1:0] acc;
    logic                        frm_ovf;
    logic signed [ACC_WIDTH:0]   base_ext;
    logic signed [ACC_WIDTH:0]   prod_ext;
    logic signed [ACC_WIDTH:0]   sum;
    logic                        sum_ovf;
    logic signed [ACC_WIDTH-1:0] acc_res;
    logic                        frm_next;

    logic                        out_valid_q;
    logic signed [ACC_WIDTH-1:0] p_q;
    logic                        ovf_q;

    assign adv      = !(out_valid_q && !OUT_READY) && !CLEAR;
    assign IN_READY = adv && RSTN;
    assign accept   = IN_VALID && IN_READY;

    assign d_ext = {D[B_WIDTH-1], D};
    assign b_ext = {B[B_WIDTH-1], B};

    always_comb begin
        pre_sum = b_ext;
        if (PRE_ADD != 0) begin
            pre_sum = PRE_SUB ? (d_ext - b_ext) : (d_ext + b_ext);
        end
    end

    // Frame position is tracked at the input so first/last travel with each sample
    // and back-to-back frames need no bubble.
    assign first_in = (cnt == '0);
    assign len_eff  = first_in ? ((FRAME_LEN == '0) ? LEN_WIDTH'(1) : FRAME_LEN) : len_q;
    assign last_in  = (cnt == len_eff - LEN_WIDTH'(1));

    assign mul_a = {{(PROD_W - A_WIDTH){s1_a[A_WIDTH-1]}}, s1_a};
    assign mul_b = {{(PROD_W - B_WIDTH - 1){s1_b[B_WIDTH]}}, s1_b};

    // One guard bit above the accumulator exposes overflow as a sign disagreement.
    assign base_ext = s2_first ? '0 : {acc[ACC_WIDTH-1], acc};
    assign prod_ext = {{(ACC_WIDTH + 1 - PROD_W){s2_prod[PROD_W-1]}}, s2_prod};
    assign sum      = base_ext + prod_ext;
    assign sum_ovf  = sum[ACC_WIDTH] ^ sum[ACC_WIDTH-1];
    assign frm_next = (s2_first ? 1'b0 : frm_ovf) | sum_ovf;

    always_comb begin
        acc_res = sum[ACC_WIDTH-1:0];
        if ((SATURATE != 0) && sum_ovf) begin
            acc_res = sum[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                     : {1'b0, {(ACC_WIDTH-1){1'b1}}};
        end
    end

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            cnt         <= '0;
            len_q       <= '0;
            s1_valid    <= 1'b0;
            s1_first    <= 1'b0;
            s1_last     <= 1'b0;
            s1_a        <= '0;
            s1_b        <= '0;
            s2_valid    <= 1'b0;
            s2_first    <= 1'b0;
            s2_last     <= 1'b0;
            s2_prod     <= '0;
            acc         <= '0;
            frm_ovf     <= 1'b0;
            out_valid_q <= 1'b0;
            p_q         <= '0;
            ovf_q       <= 1'b0;
        end else if (CLEAR) begin
            // The partial frame is dropped but a finished result still completes its handshake.
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            cnt      <= '0;
            acc      <= '0;
            frm_ovf  <= 1'b0;
            if (OUT_READY) begin
                out_valid_q <= 1'b0;
            end
        end else if (adv) begin
            s1_valid <= accept;
            if (accept) begin
                s1_a     <= A;
                s1_b     <= pre_sum;
                s1_first <= first_in;
                s1_last  <= last_in;
                cnt      <= last_in ? '0 : cnt + LEN_WIDTH'(1);
                if (first_in) begin
                    len_q <= len_eff;
                end
            end

            s2_valid <= s1_valid;
            s2_first <= s1_first;
            s2_last  <= s1_last;
            s2_prod  <= mul_a * mul_b;

            out_valid_q <= s2_valid && s2_last;
            if (s2_valid) begin
                if (s2_last) begin
                    p_q     <= acc_res;
                    ovf_q   <= frm_next;
                    acc     <= '0;
                    frm_ovf <= 1'b0;
                end else begin
                    acc     <= acc_res;
                    frm_ovf <= frm_next;
                end
            end
        end
    end

    assign OUT_VALID = out_valid_q;
    assign P         = p_q;
    assign OVF       = ovf_q;

endmodule
